// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One request is taken on in_valid/in_ready. Each cycle produces one quotient bit.
// The result is held until out_ready. A flush cancels any operation in flight.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   flush             synchronous cancel; returns the unit to IDLE
//   in_valid/in_ready request handshake; op = funct3[1:0], a = dividend, b = divisor
//   out_valid/out_ready result handshake; result = quotient or remainder
module div_unit #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [WORD_LENGTH-1:0] a,
  input  logic [WORD_LENGTH-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] result
);
  localparam int W  = WORD_LENGTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rem_op_q, rem_op_d;   // 1: REM/REMU, 0: DIV/DIVU
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [W:0]     prem_q, prem_d;       // partial remainder, one guard bit
  logic [W-1:0]   quo_q, quo_d;         // dividend shifts out, quotient shifts in
  logic [W-1:0]   dvsr_q, dvsr_d;
  logic [W-1:0]   result_q, result_d;

  // Datapath for one restoring step
  logic [W:0]     shifted;
  logic [W+1:0]   diff;
  logic           borrow;
  logic [W:0]     prem_nxt;
  logic [W-1:0]   quo_nxt;
  logic [W-1:0]   quo_fix, rem_fix;

  // Values used at request acceptance
  logic           is_signed;
  logic [W-1:0]   abs_a, abs_b;

  always_comb begin
    shifted  = {prem_q[W-1:0], quo_q[W-1]};
    diff     = {1'b0, shifted} - {2'b00, dvsr_q};
    borrow   = diff[W+1];
    prem_nxt = borrow ? shifted : diff[W:0];
    quo_nxt  = {quo_q[W-2:0], ~borrow};
    quo_fix  = neg_quo_q ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fix  = neg_rem_q ? (~prem_nxt[W-1:0] + 1'b1) : prem_nxt[W-1:0];

    is_signed = ~op[0];
    abs_a     = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
    abs_b     = (is_signed && b[W-1]) ? (~b + 1'b1) : b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_op_d  = rem_op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    prem_d    = prem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d     = '0;
          rem_op_d  = op[1];
          neg_quo_d = is_signed & (a[W-1] ^ b[W-1]);
          neg_rem_d = is_signed & a[W-1];
          if (b == '0) begin
            result_d = op[1] ? a : '1;
            state_d  = DONE;
          end else if (is_signed && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            // Signed overflow: the most negative value divided by -1.
            result_d = op[1] ? '0 : a;
            state_d  = DONE;
          end else begin
            prem_d  = '0;
            quo_d   = abs_a;
            dvsr_d  = abs_b;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = prem_nxt;
        quo_d  = quo_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          result_d = rem_op_q ? rem_fix : quo_fix;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush overrides both acceptance and completion. The last result is kept.
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      prem_q    <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_op_q  <= rem_op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      prem_q    <= prem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (WORD_LENGTH = 32).
module tb_div_unit;
  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  div_unit #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one request for exactly one accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  // The accept edge has just passed. Count edges to out_valid, check it, then consume it.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int exp_lat, input logic [31:0] exp_res);
    issue(o, x, y);
    wait_done(tag, exp_lat, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; a = '0; b = '0;
    #23;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 33, 32'd14);
    run_op("remu 100/7", REMU, 32'd100, 32'd7, 33, 32'd2);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
    run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_op("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 33, 32'd1);
    run_op("div -7/-2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'd3);
    run_op("rem -7/-2", REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFF);
    run_op("div min/2", DIV, 32'h8000_0000, 32'd2, 33, 32'hC000_0000);
    run_op("divu big/2", DIVU, 32'hFFFF_FFFF, 32'd2, 33, 32'h7FFF_FFFF);
    run_op("remu big/16", REMU, 32'hFFFF_FFFF, 32'd16, 33, 32'd15);
    run_op("divu 5/big", DIVU, 32'd5, 32'hFFFF_FFFF, 33, 32'd0);
    run_op("div 5/0", DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("rem 5/0", REM, 32'd5, 32'd0, 1, 32'd5);
    run_op("divu 5/0", DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu -7/0", REMU, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    run_op("divu min/ones", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);

    // Backpressure: the result must hold, and a new request must not be taken.
    issue(DIVU, 32'd9, 32'd3);
    for (int i = 0; i < 32 && !out_valid; i++) begin @(posedge clk); #1; end
    chk("bp done", {31'd0, out_valid}, 32'd1);
    @(negedge clk); in_valid = 1'b1; op = DIVU; a = 32'd50; b = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid held", {31'd0, out_valid}, 32'd1);
      chk("bp result held", result, 32'd3);
      chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp released in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Flush at iteration 10 while a new request is presented.
    issue(DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; op = DIVU; a = 32'd1000; b = 32'd10;
    @(posedge clk); #1;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush result kept", result, 32'd3);
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post-flush accepted", {31'd0, in_ready}, 32'd0);
    wait_done("post-flush divu", 33, 32'd100);

    // An asynchronous reset mid-operation aborts immediately.
    issue(REMU, 32'd1000, 32'd7);
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst mid in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst mid result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post-reset remu", REMU, 32'd1000, 32'd7, 33, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
